// File: rtl/approx_wallace_mac_pipe.sv
// Two-stage unsigned multiply-accumulate with a selectable approximate product.
// Low product columns collapse to the OR of their partial-product bits and emit no carry.
module approx_wallace_mac_pipe #(
   parameter int WIDTH       = 8,
   parameter int APPROX_COLS = 8,
   parameter int ACC_WIDTH   = 2*WIDTH+8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       A_in,
   input  logic [WIDTH-1:0]       B_in,
   input  logic                   approx_en,
   input  logic                   acc_en,
   input  logic                   acc_clr,
   output logic                   out_valid,
   output logic [2*WIDTH-1:0]     P_out,
   output logic [ACC_WIDTH-1:0]   ACC_out,
   output logic                   acc_ovf
);
   localparam int PW = 2*WIDTH;
   localparam logic [PW:0]   LO_FULL = ({{PW{1'b0}}, 1'b1} << APPROX_COLS) - 1'b1;
   localparam logic [PW-1:0] LO_MASK = LO_FULL[PW-1:0];

   logic             v1_reg;
   logic [WIDTH-1:0] a_reg, b_reg;
   logic             approx_reg, en_reg, clr_reg;

   logic                 v2_reg;
   logic [PW-1:0]        p_reg;
   logic [ACC_WIDTH-1:0] acc_reg;
   logic                 ovf_reg;

   logic [PW-1:0]        row [WIDTH];
   logic [PW-1:0]        hi_sum, lo_or, exact_p, approx_p, p_next;
   logic [ACC_WIDTH:0]   acc_sum;
   logic [ACC_WIDTH-1:0] acc_base, acc_add;
   logic                 ovf_next;

   // One shifted partial-product row per multiplier bit.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
         assign row[gi] = a_reg[gi] ? (PW'(b_reg) << gi) : '0;
      end
   endgenerate

   // High columns sum exactly; every term there is a multiple of 2^APPROX_COLS,
   // so the OR-compressed low columns can be merged without any carry.
   always_comb begin
      hi_sum = '0;
      lo_or  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         hi_sum = hi_sum + (row[i] & ~LO_MASK);
         lo_or  = lo_or | row[i];
      end
      approx_p = hi_sum | (lo_or & LO_MASK);
      exact_p  = PW'(a_reg) * PW'(b_reg);
      p_next   = approx_reg ? approx_p : exact_p;
   end

   always_comb begin
      acc_base = clr_reg ? '0 : acc_reg;
      acc_add  = en_reg ? ACC_WIDTH'(p_next) : '0;
      acc_sum  = {1'b0, acc_base} + {1'b0, acc_add};
      ovf_next = (clr_reg ? 1'b0 : ovf_reg) | acc_sum[ACC_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_reg     <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         approx_reg <= 1'b0;
         en_reg     <= 1'b0;
         clr_reg    <= 1'b0;
         v2_reg     <= 1'b0;
         p_reg      <= '0;
         acc_reg    <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         v1_reg <= in_valid;
         if (in_valid) begin
            a_reg      <= A_in;
            b_reg      <= B_in;
            approx_reg <= approx_en;
            en_reg     <= acc_en;
            clr_reg    <= acc_clr;
         end
         v2_reg <= v1_reg;
         if (v1_reg) begin
            p_reg   <= p_next;
            acc_reg <= acc_sum[ACC_WIDTH-1:0];
            ovf_reg <= ovf_next;
         end
      end
   end

   assign out_valid = v2_reg;
   assign P_out     = p_reg;
   assign ACC_out   = acc_reg;
   assign acc_ovf   = ovf_reg;
endmodule

// File: tb/tb_approx_wallace_mac_pipe.sv
// Directed bench: WIDTH=8, APPROX_COLS=8, ACC_WIDTH=16, plus an APPROX_COLS=0 copy.
module tb_approx_wallace_mac_pipe;
   logic        clk = 1'b0;
   logic        rst, in_valid, approx_en, acc_en, acc_clr;
   logic [7:0]  A_in, B_in;
   logic        out_valid, acc_ovf, out_valid0, acc_ovf0;
   logic [15:0] P_out, ACC_out, P_out0, ACC_out0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   approx_wallace_mac_pipe #(.WIDTH(8), .APPROX_COLS(8), .ACC_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .A_in(A_in), .B_in(B_in),
      .approx_en(approx_en), .acc_en(acc_en), .acc_clr(acc_clr),
      .out_valid(out_valid), .P_out(P_out), .ACC_out(ACC_out), .acc_ovf(acc_ovf)
   );

   approx_wallace_mac_pipe #(.WIDTH(8), .APPROX_COLS(0), .ACC_WIDTH(16)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .A_in(A_in), .B_in(B_in),
      .approx_en(approx_en), .acc_en(acc_en), .acc_clr(acc_clr),
      .out_valid(out_valid0), .P_out(P_out0), .ACC_out(ACC_out0), .acc_ovf(acc_ovf0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("check %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b,
                        input logic ap, input logic en, input logic clr);
      in_valid  = 1'b1;
      A_in      = a;
      B_in      = b;
      approx_en = ap;
      acc_en    = en;
      acc_clr   = clr;
   endtask

   initial begin
      // Reset with in_valid asserted: nothing may leak through.
      rst = 1'b1;
      drive(8'd7, 8'd7, 1'b0, 1'b1, 1'b0);
      tick(); tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_p", P_out, 0);
      chk("rst_acc", ACC_out, 0);
      chk("rst_ovf", acc_ovf, 0);
      rst = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("post_rst_valid_a", out_valid, 0);
      tick();
      chk("post_rst_valid_b", out_valid, 0);

      // Exact 255*255, then hold.
      drive(8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("exact_lat1_valid", out_valid, 0);
      tick();
      chk("exact_valid", out_valid, 1);
      chk("exact_p", P_out, 16'hFE01);
      tick();
      chk("exact_gap_valid", out_valid, 0);
      chk("exact_hold_p", P_out, 16'hFE01);

      // Back-to-back approximate / approximate / exact samples.
      drive(8'h0F, 8'h0F, 1'b1, 1'b0, 1'b0);
      tick();
      drive(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
      tick();
      drive(8'h0F, 8'h0F, 1'b0, 1'b0, 1'b0);
      chk("apx0f_valid", out_valid, 1);
      chk("apx0f_p", P_out, 16'h007F);
      chk("apx0f_cols0_p", P_out0, 16'h00E1);
      tick();
      in_valid = 1'b0;
      chk("apxff_p", P_out, 16'hF7FF);
      chk("apxff_cols0_p", P_out0, 16'hFE01);
      tick();
      chk("exact0f_valid", out_valid, 1);
      chk("exact0f_p", P_out, 16'h00E1);
      tick();
      chk("mode_gap_valid", out_valid, 0);

      // Accumulate read-after-write.
      drive(8'd3, 8'd4, 1'b0, 1'b1, 1'b1);
      tick();
      drive(8'd5, 8'd6, 1'b0, 1'b1, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("acc12_valid", out_valid, 1);
      chk("acc12", ACC_out, 12);
      tick();
      chk("acc42_valid", out_valid, 1);
      chk("acc42", ACC_out, 42);
      tick();
      chk("acc_hold_valid", out_valid, 0);
      chk("acc_hold", ACC_out, 42);

      // Overflow, sticky hold, clear.
      drive(8'd255, 8'd255, 1'b0, 1'b1, 1'b1);
      tick();
      drive(8'd255, 8'd255, 1'b0, 1'b1, 1'b0);
      tick();
      drive(8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      chk("ovf_acc1", ACC_out, 65025);
      chk("ovf_flag1", acc_ovf, 0);
      tick();
      drive(8'd1, 8'd1, 1'b0, 1'b1, 1'b1);
      chk("ovf_acc2", ACC_out, 64514);
      chk("ovf_flag2", acc_ovf, 1);
      tick();
      in_valid = 1'b0;
      chk("ovf_sticky_acc", ACC_out, 64514);
      chk("ovf_sticky_flag", acc_ovf, 1);
      tick();
      chk("ovf_clr_acc", ACC_out, 1);
      chk("ovf_clr_flag", acc_ovf, 0);

      // Bubble pattern 1,0,1.
      drive(8'd2, 8'd3, 1'b0, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();
      drive(8'd4, 8'd5, 1'b0, 1'b0, 1'b0);
      chk("bub_v1", out_valid, 1);
      chk("bub_p1", P_out, 6);
      tick();
      in_valid = 1'b0;
      chk("bub_v0", out_valid, 0);
      chk("bub_hold", P_out, 6);
      tick();
      chk("bub_v2", out_valid, 1);
      chk("bub_p2", P_out, 20);
      tick();

      // Reset mid-operation with samples in flight.
      drive(8'd9, 8'd9, 1'b0, 1'b1, 1'b0);
      tick();
      rst = 1'b1;
      drive(8'd8, 8'd8, 1'b0, 1'b1, 1'b0);
      tick();
      chk("midrst_valid_a", out_valid, 0);
      chk("midrst_p", P_out, 0);
      chk("midrst_acc", ACC_out, 0);
      chk("midrst_ovf", acc_ovf, 0);
      rst = 1'b0;
      drive(8'd6, 8'd7, 1'b0, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("midrst_valid_b", out_valid, 0);
      chk("midrst_p_b", P_out, 0);
      tick();
      chk("first_valid", out_valid, 1);
      chk("first_p", P_out, 42);
      tick();
      chk("first_gap_valid", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
